// File: rtl/puf_scan_driver.sv
// Host-side PUF scan-chain controller: serially loads two 128-bit challenges on PH1/PH2,
// pulses Trig, then unloads and assembles the upper/lower responses.
module puf_scan_driver #(
  parameter int unsigned PH_DIV      = 2,
  parameter int unsigned TRIG_CYCLES = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] challenge_a,
  input  logic [127:0] challenge_b,
  output logic         busy,
  output logic         done,
  output logic [127:0] response_up,
  output logic [127:0] response_down,
  output logic         PH1,
  output logic         PH2,
  output logic         CA_SI,
  output logic         CB_SI,
  output logic         Ph_En,
  output logic         OutEn,
  output logic         Trig,
  input  logic         SO_Up,
  input  logic         SO_Down
);

  localparam int unsigned CHAL_BITS = 128;
  localparam int unsigned BIT_W     = 7;
  localparam int unsigned DIV_W     = (PH_DIV > 1) ? $clog2(PH_DIV) : 1;
  localparam int unsigned TRG_W     = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PH_DIV - 1);
  localparam logic [TRG_W-1:0] TRG_LAST = TRG_W'(TRIG_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAL_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_TRIG_HI = 3'd2,
    S_TRIG_LO = 3'd3,
    S_UNLOAD  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DIV_W-1:0]   r_div;
  logic [1:0]         r_slot;
  logic [BIT_W-1:0]   r_bit;
  logic [TRG_W-1:0]   r_tcnt;
  logic [127:0]       r_sha;
  logic [127:0]       r_shb;

  logic w_scan, w_div_wrap, w_period_end, w_scan_end, w_trig_end, w_sample;
  logic w_busy, w_done, w_ph1, w_ph2, w_ca, w_cb, w_ph_en, w_out_en, w_trig;

  assign w_scan       = (r_state == S_LOAD) || (r_state == S_UNLOAD);
  assign w_div_wrap   = (r_div == DIV_LAST);
  assign w_period_end = w_scan && w_div_wrap && (r_slot == 2'd3);
  assign w_scan_end   = w_period_end && (r_bit == BIT_LAST);
  assign w_trig_end   = (r_tcnt == TRG_LAST);
  // Last cycle of slot0 as seen on the registered pins: PH1 rises on this edge.
  assign w_sample     = (r_state == S_UNLOAD) && (r_slot == 2'd1) && (r_div == DIV_W'(0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and next values of the pin registers.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_ph1       = 1'b0;
    w_ph2       = 1'b0;
    w_ca        = 1'b0;
    w_cb        = 1'b0;
    w_ph_en     = 1'b0;
    w_out_en    = 1'b0;
    w_trig      = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_LOAD;
      S_LOAD:    if (w_scan_end) w_state_nxt = S_TRIG_HI;
      S_TRIG_HI: if (w_trig_end) w_state_nxt = S_TRIG_LO;
      S_TRIG_LO: if (w_trig_end) w_state_nxt = S_UNLOAD;
      S_UNLOAD:  if (w_scan_end) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    w_busy   = (r_state != S_IDLE);
    w_done   = (r_state == S_DONE);
    w_ph1    = w_scan && (r_slot == 2'd1);
    w_ph2    = w_scan && (r_slot == 2'd3);
    w_ph_en  = (r_state == S_LOAD);
    w_ca     = w_ph_en && r_sha[0];
    w_cb     = w_ph_en && r_shb[0];
    w_out_en = (r_state == S_UNLOAD);
    w_trig   = (r_state == S_TRIG_HI);
  end

  // Scan timing counters and challenge shift registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_slot <= '0;
      r_bit  <= '0;
      r_tcnt <= '0;
      r_sha  <= '0;
      r_shb  <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_sha <= challenge_a;
        r_shb <= challenge_b;
      end else if ((r_state == S_LOAD) && w_period_end) begin
        r_sha <= {1'b0, r_sha[127:1]};
        r_shb <= {1'b0, r_shb[127:1]};
      end
      if (w_scan) begin
        r_div <= w_div_wrap ? '0 : r_div + DIV_W'(1);
        if (w_div_wrap)   r_slot <= r_slot + 2'd1;
        if (w_period_end) r_bit  <= r_bit + BIT_W'(1);
      end else begin
        r_div  <= '0;
        r_slot <= '0;
      end
      if ((r_state == S_TRIG_HI) || (r_state == S_TRIG_LO))
        r_tcnt <= w_trig_end ? '0 : r_tcnt + TRG_W'(1);
      else
        r_tcnt <= '0;
    end
  end

  // Registered pins and response assembly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      PH1           <= 1'b0;
      PH2           <= 1'b0;
      CA_SI         <= 1'b0;
      CB_SI         <= 1'b0;
      Ph_En         <= 1'b0;
      OutEn         <= 1'b0;
      Trig          <= 1'b0;
      response_up   <= '0;
      response_down <= '0;
    end else begin
      busy  <= w_busy;
      done  <= w_done;
      PH1   <= w_ph1;
      PH2   <= w_ph2;
      CA_SI <= w_ca;
      CB_SI <= w_cb;
      Ph_En <= w_ph_en;
      OutEn <= w_out_en;
      Trig  <= w_trig;
      if (w_sample) begin
        response_up[r_bit]   <= SO_Up;
        response_down[r_bit] <= SO_Down;
      end
    end
  end

endmodule

// File: tb/tb_puf_scan_driver.sv
// Bench for puf_scan_driver: behavioural PUF on the scan pins, pin-protocol monitor,
// and expected responses computed as whole-vector A|B and A&B.
module tb_puf_scan_driver;

  localparam int unsigned PH_DIV      = 2;
  localparam int unsigned TRIG_CYCLES = 8;
  localparam int unsigned LAT         = 1 + 1024 * PH_DIV + 2 * TRIG_CYCLES;
  localparam int unsigned SCAN_CYC    = 512 * PH_DIV;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] challenge_a = '0;
  logic [127:0] challenge_b = '0;
  logic         busy, done, PH1, PH2, CA_SI, CB_SI, Ph_En, OutEn, Trig;
  logic [127:0] response_up, response_down;
  logic         SO_Up, SO_Down;

  always #5 clk = ~clk;

  puf_scan_driver #(.PH_DIV(PH_DIV), .TRIG_CYCLES(TRIG_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .challenge_a(challenge_a), .challenge_b(challenge_b),
    .busy(busy), .done(done),
    .response_up(response_up), .response_down(response_down),
    .PH1(PH1), .PH2(PH2), .CA_SI(CA_SI), .CB_SI(CB_SI),
    .Ph_En(Ph_En), .OutEn(OutEn), .Trig(Trig),
    .SO_Up(SO_Up), .SO_Down(SO_Down)
  );

  // PUF model: 7-bit index with no reset, advanced by every PH1 rise.
  logic [127:0] puf_a = '0;
  logic [127:0] puf_b = '0;
  logic [6:0]   puf_idx = '0;
  always @(posedge PH1) begin
    if (Ph_En) begin
      puf_a[puf_idx] <= CA_SI;
      puf_b[puf_idx] <= CB_SI;
    end
    puf_idx <= puf_idx + 7'd1;
  end
  assign SO_Up   = puf_a[puf_idx] | puf_b[puf_idx];
  assign SO_Down = puf_a[puf_idx] & puf_b[puf_idx];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned ph1_load = 0, ph1_unload = 0, pe_cyc = 0, oe_cyc = 0, trig_cyc = 0;
  int unsigned done_cnt = 0, viol = 0;
  logic m_ph1 = 1'b0, m_ca = 1'b0, m_cb = 1'b0;

  // Pin monitor, sampled 2 ns after each rising edge.
  always @(posedge clk) begin
    #2;
    if (PH1 && !m_ph1) begin
      if (Ph_En)      ph1_load   <= ph1_load + 1;
      else if (OutEn) ph1_unload <= ph1_unload + 1;
    end
    if (Ph_En) pe_cyc   <= pe_cyc + 1;
    if (OutEn) oe_cyc   <= oe_cyc + 1;
    if (Trig)  trig_cyc <= trig_cyc + 1;
    if (done)  done_cnt <= done_cnt + 1;
    if ((PH1 && PH2) ||
        (PH1 && m_ph1 && ((CA_SI !== m_ca) || (CB_SI !== m_cb))) ||
        (Ph_En && OutEn) ||
        ((PH1 || PH2) && !Ph_En && !OutEn) ||
        (Trig && (Ph_En || OutEn)) ||
        ((Ph_En || OutEn || Trig || done) && !busy))
      viol <= viol + 1;
    m_ph1 <= PH1;
    m_ca  <= CA_SI;
    m_cb  <= CB_SI;
  end

  int unsigned n_assert = 0, n_fail = 0;
  int unsigned b_pl, b_pu, b_pe, b_oe, b_tr, b_dn, b_viol;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_pl = ph1_load; b_pu = ph1_unload; b_pe = pe_cyc; b_oe = oe_cyc;
    b_tr = trig_cyc; b_dn = done_cnt;   b_viol = viol;
  endtask

  // t0 is the edge count at which start is sampled.
  task automatic launch(input logic [127:0] a, input logic [127:0] b, input bit hold,
                        output int unsigned t0);
    @(negedge clk);
    snap();
    challenge_a = a;
    challenge_b = b;
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    if (!hold) begin
      start = 1'b0;
      challenge_a = {$urandom(), $urandom(), $urandom(), $urandom()};
      challenge_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  task automatic wait_done(input string tag, output int unsigned dcyc);
    int unsigned n = 0;
    while (done !== 1'b1 && n < 3 * LAT) begin
      @(negedge clk);
      n++;
    end
    n_assert++;
    assert (done === 1'b1) else begin
      n_fail++;
      $error("FAIL %s_timeout: done observed %b after %0d cycles, required 1", tag, done, n);
    end
    dcyc = cyc;
  endtask

  task automatic check_txn(input string tag, input logic [127:0] a, input logic [127:0] b,
                           input int unsigned t0, input int unsigned dcyc);
    chk({tag, "_latency"}, 128'(dcyc - t0), 128'(LAT));
    chk({tag, "_resp_up"}, response_up, a | b);
    chk({tag, "_resp_down"}, response_down, a & b);
    chk({tag, "_ph1_load"}, 128'(ph1_load - b_pl), 128'(128));
    chk({tag, "_ph1_unload"}, 128'(ph1_unload - b_pu), 128'(128));
    chk({tag, "_phen_cycles"}, 128'(pe_cyc - b_pe), 128'(SCAN_CYC));
    chk({tag, "_outen_cycles"}, 128'(oe_cyc - b_oe), 128'(SCAN_CYC));
    chk({tag, "_trig_cycles"}, 128'(trig_cyc - b_tr), 128'(TRIG_CYCLES));
    chk({tag, "_done_pulses"}, 128'(done_cnt - b_dn), 128'(1));
    chk({tag, "_protocol"}, 128'(viol - b_viol), 128'(0));
  endtask

  initial begin
    int unsigned t0, d1, d2, n;
    logic [127:0] a, b, r1u, r1d;

    // Reset with random inputs.
    start = 1'b1;
    challenge_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    challenge_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    repeat (3) @(negedge clk);
    chk("rst_ctl", 128'({busy, done, PH1, PH2, CA_SI, CB_SI, Ph_En, OutEn, Trig}), 128'(0));
    chk("rst_resp_up", response_up, '0);
    chk("rst_resp_down", response_down, '0);
    start = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 128'(busy), 128'(0));
    chk("post_rst_ph", 128'({PH1, PH2}), 128'(0));

    // All-ones A, zero B.
    a = '1; b = '0;
    launch(a, b, 1'b0, t0);
    wait_done("ones", d1);
    check_txn("ones", a, b, t0, d1);

    // Alternating patterns.
    a = {32{4'hA}}; b = {4{32'hFFFF0000}};
    launch(a, b, 1'b0, t0);
    wait_done("alt", d1);
    check_txn("alt", a, b, t0, d1);

    // Back-to-back with start held: second launch on the edge ending the done cycle.
    launch(a, b, 1'b1, t0);
    wait_done("b2b1", d1);
    check_txn("b2b1", a, b, t0, d1);
    r1u = response_up;
    r1d = response_down;
    snap();
    t0 = d1 + 1;
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b2", d2);
    check_txn("b2b2", a, b, t0, d2);
    chk("b2b_same_up", response_up, r1u);
    chk("b2b_same_down", response_down, r1d);

    // Start pulsed mid-LOAD and during the DONE state: both ignored.
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    launch(a, b, 1'b0, t0);
    while (cyc < t0 + 300) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + LAT - 1) @(negedge clk);
    chk("ign_pre_done", 128'(done), 128'(0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_done_edge", 128'(done), 128'(1));
    d1 = cyc;
    repeat (20) @(negedge clk);
    chk("ign_idle_busy", 128'(busy), 128'(0));
    check_txn("ign", a, b, t0, d1);

    // Reset at bit 40 of LOAD, then a fresh transaction.
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    launch(a, b, 1'b0, t0);
    n = 0;
    while ((ph1_load - b_pl) < 40 && n < LAT) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_reached", 128'(ph1_load - b_pl), 128'(40));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 128'({busy, done, PH1, PH2, CA_SI, CB_SI, Ph_En, OutEn, Trig}), 128'(0));
    chk("mid_rst_resp", response_up | response_down, '0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_rst_idle", 128'({busy, Ph_En, PH1}), 128'(0));
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    launch(a, b, 1'b0, t0);
    wait_done("recover", d1);
    check_txn("recover", a, b, t0, d1);

    // Random challenges.
    for (int i = 0; i < 2; i++) begin
      a = {$urandom(), $urandom(), $urandom(), $urandom()};
      b = {$urandom(), $urandom(), $urandom(), $urandom()};
      launch(a, b, 1'b0, t0);
      wait_done("rand", d1);
      check_txn("rand", a, b, t0, d1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
